ao486_l15_req_arbiter: RTL and testbench

// Shares the single L1.5 request/response channel between the ao486 Avalon memory bus and Avalon IO bus.
// One outstanding L1.5 transaction at a time; round-robin grant; read data routed back to the originating bus.

---
 rtl/ao486_l15_req_arbiter_pkg.sv | 50 +++++
 rtl/ao486_l15_req_arbiter_if.sv | 66 ++++++
 rtl/ao486_l15_be_decode.sv | 40 ++++
 rtl/ao486_l15_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ao486_l15_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ao486_l15_req_arbiter_pkg.sv
// Shared L1.5 request/return encodings and helpers for the ao486
// memory/IO bus to L1.5 arbiter.
package ao486_l15_req_arbiter_pkg;

  localparam int PHY_ADDR_WIDTH = 40;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;
  localparam logic [3:0] INT_RET  = 4'b0111;

  localparam logic [2:0] PCX_SZ_1B = 3'b000;
  localparam logic [2:0] PCX_SZ_2B = 3'b001;
  localparam logic [2:0] PCX_SZ_4B = 3'b010;

  typedef struct packed {
    logic                      is_mem;
    logic                      write;
    logic [PHY_ADDR_WIDTH-1:0] addr;
    logic [3:0]                be;
    logic [31:0]               wdata;
    logic                      nc;
    logic [2:0]                burst;
    logic [1:0]                widx;
  } cmd_t;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // line = {data_0, data_1}; word 0 is the upper half of data_0
  function automatic logic [31:0] line_word(
    input logic [127:0] line,
    input logic [1:0]   idx
  );
    logic [31:0] w;
    w = line[127:96];
    unique case (idx)
      2'd0: w = line[127:96];
      2'd1: w = line[95:64];
      2'd2: w = line[63:32];
      2'd3: w = line[31:0];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ao486_l15_req_arbiter_if.sv
// Avalon mem/IO buses and the L1.5 request/response channel
// seen by the arbiter (slave) and by the agents around it (master).
interface ao486_l15_req_arbiter_if;
  import ao486_l15_req_arbiter_pkg::*;

  logic [29:0]               mem_address;
  logic [31:0]               mem_writedata;
  logic [3:0]                mem_byteenable;
  logic [2:0]                mem_burstcount;
  logic                      mem_read;
  logic                      mem_write;
  logic                      mem_waitrequest;
  logic                      mem_readdatavalid;
  logic [31:0]               mem_readdata;

  logic [15:0]               io_address;
  logic [31:0]               io_writedata;
  logic [3:0]                io_byteenable;
  logic                      io_read;
  logic                      io_write;
  logic                      io_waitrequest;
  logic                      io_readdatavalid;
  logic [31:0]               io_readdata;

  logic                      l15_val;
  logic [4:0]                l15_rqtype;
  logic [2:0]                l15_size;
  logic                      l15_nc;
  logic [PHY_ADDR_WIDTH-1:0] l15_address;
  logic [63:0]               l15_data;
  logic                      l15_ack;
  logic                      l15_rsp_val;
  logic [3:0]                l15_returntype;
  logic [63:0]               l15_data_0;
  logic [63:0]               l15_data_1;
  logic                      l15_req_ack;

  modport slave (
    input  mem_address, mem_writedata, mem_byteenable,
    input  mem_burstcount, mem_read, mem_write,
    output mem_waitrequest, mem_readdatavalid, mem_readdata,
    input  io_address, io_writedata, io_byteenable,
    input  io_read, io_write,
    output io_waitrequest, io_readdatavalid, io_readdata,
    output l15_val, l15_rqtype, l15_size, l15_nc,
    output l15_address, l15_data,
    input  l15_ack, l15_rsp_val, l15_returntype,
    input  l15_data_0, l15_data_1,
    output l15_req_ack
  );

  modport master (
    output mem_address, mem_writedata, mem_byteenable,
    output mem_burstcount, mem_read, mem_write,
    input  mem_waitrequest, mem_readdatavalid, mem_readdata,
    output io_address, io_writedata, io_byteenable,
    output io_read, io_write,
    input  io_waitrequest, io_readdatavalid, io_readdata,
    input  l15_val, l15_rqtype, l15_size, l15_nc,
    input  l15_address, l15_data,
    output l15_ack, l15_rsp_val, l15_returntype,
    output l15_data_0, l15_data_1,
    input  l15_req_ack
  );

endinterface

// File: rtl/ao486_l15_be_decode.sv
// Avalon byteenable -> L1.5 access size and byte offset in the word.
// Patterns that are not 1B/2B aligned fall back to a full word.
module ao486_l15_be_decode
  import ao486_l15_req_arbiter_pkg::*;
(
  input  logic [3:0] be_i,
  output logic [2:0] size_o,
  output logic [1:0] off_o
);

  always_comb begin
    size_o = PCX_SZ_4B;
    off_o  = 2'd0;
    case (be_i)
      4'b0011: size_o = PCX_SZ_2B;
      4'b1100: begin
        size_o = PCX_SZ_2B;
        off_o  = 2'd2;
      end
      4'b0001: size_o = PCX_SZ_1B;
      4'b0010: begin
        size_o = PCX_SZ_1B;
        off_o  = 2'd1;
      end
      4'b0100: begin
        size_o = PCX_SZ_1B;
        off_o  = 2'd2;
      end
      4'b1000: begin
        size_o = PCX_SZ_1B;
        off_o  = 2'd3;
      end
      default: begin
        size_o = PCX_SZ_4B;
        off_o  = 2'd0;
      end
    endcase
  end

endmodule

// File: rtl/ao486_l15_req_arbiter.sv
// Round-robin arbiter sharing one L1.5 channel between the ao486
// Avalon mem and IO buses; mem bursts replay from a line buffer.
module ao486_l15_req_arbiter
  import ao486_l15_req_arbiter_pkg::*;
#(
  parameter logic [PHY_ADDR_WIDTH-1:0] IO_BASE = 40'hFF_0000_0000,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  ao486_l15_req_arbiter_if.slave bus
);

  localparam int PW = PHY_ADDR_WIDTH;
  localparam logic [2:0] MAX_BC = 3'(MAX_BURST);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_BURST = 2'd3;

  logic [1:0]   state_q, state_d;
  logic         last_io_q, last_io_d;
  cmd_t         cmd_q, cmd_d;
  logic [2:0]   beat_q, beat_d;
  logic [127:0] line_q, line_d;
  logic [31:0]  mem_rdata_q, mem_rdata_d;
  logic [31:0]  io_rdata_q, io_rdata_d;
  logic         mem_rdv_q, mem_rdv_d;
  logic         io_rdv_q, io_rdv_d;

  logic         pend_m, pend_i, take_mem, ack_now, emit;
  logic [2:0]   dec_size, mem_bc;
  logic [1:0]   dec_off, bidx;
  logic [127:0] rsp_line;
  logic [31:0]  beat_word;
  logic         io_unused;

  assign pend_m   = bus.mem_read | bus.mem_write;
  assign pend_i   = bus.io_read | bus.io_write;
  assign take_mem = pend_m & (~pend_i | last_io_q);
  assign ack_now  = (state_q == S_ISSUE) & bus.l15_ack;
  assign rsp_line = {bus.l15_data_0, bus.l15_data_1};
  assign bidx     = cmd_q.widx + beat_q[1:0];
  assign io_unused = ^bus.io_address[1:0];

  assign mem_bc =
    (bus.mem_burstcount == 3'd0)  ? 3'd1   :
    (bus.mem_burstcount > MAX_BC) ? MAX_BC :
    bus.mem_burstcount;

  // Beat 0 comes straight off the return bus, later beats from the buffer
  assign beat_word = swap32(line_word(
    (state_q == S_BURST) ? line_q : rsp_line, bidx));

  ao486_l15_be_decode u_be_dec (
    .be_i   (cmd_q.be),
    .size_o (dec_size),
    .off_o  (dec_off)
  );

  always_comb begin
    state_d     = state_q;
    last_io_d   = last_io_q;
    cmd_d       = cmd_q;
    beat_d      = beat_q;
    line_d      = line_q;
    mem_rdata_d = mem_rdata_q;
    io_rdata_d  = io_rdata_q;
    mem_rdv_d   = 1'b0;
    io_rdv_d    = 1'b0;
    emit        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_m | pend_i) begin
          state_d   = S_ISSUE;
          last_io_d = ~take_mem;
          beat_d    = 3'd0;
          if (take_mem) begin
            cmd_d.is_mem = 1'b1;
            cmd_d.write  = bus.mem_write;
            cmd_d.addr   = {{(PW-32){1'b0}}, bus.mem_address, 2'b00};
            cmd_d.be     = bus.mem_byteenable;
            cmd_d.wdata  = bus.mem_writedata;
            cmd_d.nc     = bus.mem_address[29];
            cmd_d.burst  = mem_bc;
            cmd_d.widx   = bus.mem_address[1:0];
          end else begin
            cmd_d.is_mem = 1'b0;
            cmd_d.write  = bus.io_write;
            cmd_d.addr   = IO_BASE |
              {{(PW-16){1'b0}}, bus.io_address[15:2], 2'b00};
            cmd_d.be     = bus.io_byteenable;
            cmd_d.wdata  = bus.io_writedata;
            cmd_d.nc     = 1'b1;
            cmd_d.burst  = 3'd1;
            cmd_d.widx   = bus.io_address[3:2];
          end
        end
      end
      S_ISSUE: begin
        if (bus.l15_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.l15_rsp_val) begin
          if (bus.l15_returntype == LOAD_RET) begin
            line_d  = rsp_line;
            beat_d  = 3'd1;
            emit    = 1'b1;
            state_d = (cmd_q.burst > 3'd1) ? S_BURST : S_IDLE;
          end else if (bus.l15_returntype == ST_ACK) begin
            state_d = S_IDLE;
          end
        end
      end
      S_BURST: begin
        emit   = 1'b1;
        beat_d = beat_q + 3'd1;
        if (beat_q == cmd_q.burst - 3'd1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (emit) begin
      if (cmd_q.is_mem) begin
        mem_rdv_d   = 1'b1;
        mem_rdata_d = beat_word;
      end else begin
        io_rdv_d   = 1'b1;
        io_rdata_d = beat_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_io_q   <= 1'b1;
      cmd_q       <= '0;
      beat_q      <= 3'd0;
      line_q      <= '0;
      mem_rdata_q <= '0;
      io_rdata_q  <= '0;
      mem_rdv_q   <= 1'b0;
      io_rdv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_io_q   <= last_io_d;
      cmd_q       <= cmd_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      mem_rdata_q <= mem_rdata_d;
      io_rdata_q  <= io_rdata_d;
      mem_rdv_q   <= mem_rdv_d;
      io_rdv_q    <= io_rdv_d;
    end
  end

  assign bus.l15_val     = (state_q == S_ISSUE);
  assign bus.l15_rqtype  = cmd_q.write ? STORE_RQ : LOAD_RQ;
  assign bus.l15_size    = dec_size;
  assign bus.l15_nc      = cmd_q.nc;
  assign bus.l15_address = cmd_q.addr | {{(PW-2){1'b0}}, dec_off};
  assign bus.l15_data    = {swap32(cmd_q.wdata), swap32(cmd_q.wdata)};
  assign bus.l15_req_ack = bus.l15_rsp_val;

  assign bus.mem_waitrequest   = pend_m & ~(cmd_q.is_mem & ack_now);
  assign bus.io_waitrequest    = pend_i & ~(~cmd_q.is_mem & ack_now);
  assign bus.mem_readdatavalid = mem_rdv_q;
  assign bus.mem_readdata      = mem_rdata_q;
  assign bus.io_readdatavalid  = io_rdv_q;
  assign bus.io_readdata       = io_rdata_q;

endmodule

// File: tb/tb_ao486_l15_req_arbiter.sv
// Directed bench for the ao486 L1.5 request arbiter: reads, bursts,
// arbitration, IO mapping, reset abandon and ignored returns.
module tb_ao486_l15_req_arbiter;
  import ao486_l15_req_arbiter_pkg::*;

  localparam logic [39:0] IOB = 40'hFF_0000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  ao486_l15_req_arbiter_if bus ();

  ao486_l15_req_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.mem_address    = '0;
    bus.mem_writedata  = '0;
    bus.mem_byteenable = '0;
    bus.mem_burstcount = '0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.io_address     = '0;
    bus.io_writedata   = '0;
    bus.io_byteenable  = '0;
    bus.io_read        = 1'b0;
    bus.io_write       = 1'b0;
    bus.l15_ack        = 1'b0;
    bus.l15_rsp_val    = 1'b0;
    bus.l15_returntype = '0;
    bus.l15_data_0     = '0;
    bus.l15_data_1     = '0;
  endtask

  task automatic rsp(
    input logic [3:0]  t,
    input logic [63:0] d0,
    input logic [63:0] d1
  );
    bus.l15_rsp_val    = 1'b1;
    bus.l15_returntype = t;
    bus.l15_data_0     = d0;
    bus.l15_data_1     = d1;
  endtask

  task automatic mem_cmd(
    input logic        wr,
    input logic [29:0] a,
    input logic [3:0]  be,
    input logic [2:0]  bc,
    input logic [31:0] wd
  );
    bus.mem_read       = ~wr;
    bus.mem_write      = wr;
    bus.mem_address    = a;
    bus.mem_byteenable = be;
    bus.mem_burstcount = bc;
    bus.mem_writedata  = wd;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_val", 64'(bus.l15_val), 64'd0);
    chk("rst_mrdv", 64'(bus.mem_readdatavalid), 64'd0);
    chk("rst_irdv", 64'(bus.io_readdatavalid), 64'd0);
    chk("rst_mrd", 64'(bus.mem_readdata), 64'd0);
    chk("rst_mwait", 64'(bus.mem_waitrequest), 64'd0);

    // single-word mem read, ack on second ISSUE cycle
    mem_cmd(1'b0, 30'h100, 4'b1111, 3'd1, 32'h0);
    #1;
    chk("t1_wait_idle", 64'(bus.mem_waitrequest), 64'd1);
    step();
    chk("t1_val", 64'(bus.l15_val), 64'd1);
    chk("t1_addr", 64'(bus.l15_address), 64'h400);
    chk("t1_size", 64'(bus.l15_size), 64'(PCX_SZ_4B));
    chk("t1_rqtype", 64'(bus.l15_rqtype), 64'(LOAD_RQ));
    chk("t1_wait_noack", 64'(bus.mem_waitrequest), 64'd1);
    step();
    bus.l15_ack = 1'b1;
    #1;
    chk("t1_val2", 64'(bus.l15_val), 64'd1);
    chk("t1_wait_ack", 64'(bus.mem_waitrequest), 64'd0);
    step();
    bus.l15_ack  = 1'b0;
    bus.mem_read = 1'b0;
    chk("t1_val_wait", 64'(bus.l15_val), 64'd0);
    rsp(LOAD_RET, 64'h11223344_55667788, 64'h0);
    #1;
    chk("t1_req_ack", 64'(bus.l15_req_ack), 64'd1);
    chk("t1_rdv_early", 64'(bus.mem_readdatavalid), 64'd0);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t1_rdv", 64'(bus.mem_readdatavalid), 64'd1);
    chk("t1_rd", 64'(bus.mem_readdata), 64'h44332211);
    chk("t1_irdv", 64'(bus.io_readdatavalid), 64'd0);
    step();
    chk("t1_rdv_off", 64'(bus.mem_readdatavalid), 64'd0);
    chk("t1_rd_hold", 64'(bus.mem_readdata), 64'h44332211);

    // 4-beat burst starting at word 2, wraps inside the line
    mem_cmd(1'b0, 30'h202, 4'b1111, 3'd4, 32'h0);
    step();
    chk("t2_addr", 64'(bus.l15_address), 64'h808);
    bus.l15_ack = 1'b1;
    step();
    bus.l15_ack  = 1'b0;
    bus.mem_read = 1'b0;
    rsp(LOAD_RET, 64'hA0A1A2A3_B0B1B2B3, 64'hC0C1C2C3_D0D1D2D3);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t2_b0_v", 64'(bus.mem_readdatavalid), 64'd1);
    chk("t2_b0", 64'(bus.mem_readdata), 64'hC3C2C1C0);
    step();
    chk("t2_b1_v", 64'(bus.mem_readdatavalid), 64'd1);
    chk("t2_b1", 64'(bus.mem_readdata), 64'hD3D2D1D0);
    chk("t2_b1_val", 64'(bus.l15_val), 64'd0);
    step();
    chk("t2_b2_v", 64'(bus.mem_readdatavalid), 64'd1);
    chk("t2_b2", 64'(bus.mem_readdata), 64'hA3A2A1A0);
    chk("t2_b2_val", 64'(bus.l15_val), 64'd0);
    step();
    chk("t2_b3_v", 64'(bus.mem_readdatavalid), 64'd1);
    chk("t2_b3", 64'(bus.mem_readdata), 64'hB3B2B1B0);
    chk("t2_b3_val", 64'(bus.l15_val), 64'd0);
    step();
    chk("t2_end", 64'(bus.mem_readdatavalid), 64'd0);
    chk("t2_end_val", 64'(bus.l15_val), 64'd0);

    // simultaneous writes from reset: mem first, then io
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mem_cmd(1'b1, 30'h40, 4'b1111, 3'd1, 32'hDEADBEEF);
    bus.io_write      = 1'b1;
    bus.io_address    = 16'h0060;
    bus.io_byteenable = 4'b1111;
    bus.io_writedata  = 32'h12345678;
    step();
    chk("t3_m_addr", 64'(bus.l15_address), 64'h100);
    chk("t3_m_rq", 64'(bus.l15_rqtype), 64'(STORE_RQ));
    chk("t3_m_data", bus.l15_data, 64'hEFBEADDE_EFBEADDE);
    bus.l15_ack = 1'b1;
    #1;
    chk("t3_m_wait", 64'(bus.mem_waitrequest), 64'd0);
    chk("t3_i_wait", 64'(bus.io_waitrequest), 64'd1);
    step();
    bus.l15_ack   = 1'b0;
    bus.mem_write = 1'b0;
    rsp(ST_ACK, 64'h0, 64'h0);
    #1;
    chk("t3_stack", 64'(bus.l15_req_ack), 64'd1);
    chk("t3_i_wait2", 64'(bus.io_waitrequest), 64'd1);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t3_no_rdv", 64'(bus.mem_readdatavalid), 64'd0);
    step();
    chk("t3_i_val", 64'(bus.l15_val), 64'd1);
    chk("t3_i_addr", 64'(bus.l15_address), 64'(IOB | 40'h60));
    chk("t3_i_nc", 64'(bus.l15_nc), 64'd1);
    chk("t3_i_data", bus.l15_data, 64'h78563412_78563412);
    chk("t3_i_wait3", 64'(bus.io_waitrequest), 64'd1);
    bus.l15_ack = 1'b1;
    #1;
    chk("t3_i_wait_ack", 64'(bus.io_waitrequest), 64'd0);
    step();
    bus.l15_ack  = 1'b0;
    bus.io_write = 1'b0;
    rsp(ST_ACK, 64'h0, 64'h0);
    step();
    bus.l15_rsp_val = 1'b0;

    // io byte read, data routed to io bus only
    bus.io_read       = 1'b1;
    bus.io_address    = 16'h0064;
    bus.io_byteenable = 4'b0100;
    step();
    chk("t4_size", 64'(bus.l15_size), 64'(PCX_SZ_1B));
    chk("t4_addr", 64'(bus.l15_address), 64'(IOB | 40'h66));
    bus.l15_ack = 1'b1;
    step();
    bus.l15_ack = 1'b0;
    bus.io_read = 1'b0;
    rsp(LOAD_RET, 64'h01020304_05060708, 64'h0);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t4_irdv", 64'(bus.io_readdatavalid), 64'd1);
    chk("t4_ird", 64'(bus.io_readdata), 64'h08070605);
    chk("t4_mrdv", 64'(bus.mem_readdatavalid), 64'd0);
    chk("t4_mrd", 64'(bus.mem_readdata), 64'h0);

    // reset while waiting, stale return dropped, then normal request
    mem_cmd(1'b0, 30'h10, 4'b1111, 3'd1, 32'h0);
    step();
    bus.l15_ack = 1'b1;
    step();
    bus.l15_ack  = 1'b0;
    bus.mem_read = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    rsp(LOAD_RET, 64'h55555555_55555555, 64'h0);
    #1;
    chk("t5_stale_ack", 64'(bus.l15_req_ack), 64'd1);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t5_stale_rdv", 64'(bus.mem_readdatavalid), 64'd0);
    chk("t5_stale_val", 64'(bus.l15_val), 64'd0);
    mem_cmd(1'b0, 30'h21, 4'b0011, 3'd0, 32'h0);
    step();
    chk("t5_val", 64'(bus.l15_val), 64'd1);
    chk("t5_size", 64'(bus.l15_size), 64'(PCX_SZ_2B));
    chk("t5_addr", 64'(bus.l15_address), 64'h84);
    bus.l15_ack = 1'b1;
    step();
    bus.l15_ack  = 1'b0;
    bus.mem_read = 1'b0;
    rsp(LOAD_RET, 64'hCAFEF00D_87654321, 64'h0);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t5_rdv", 64'(bus.mem_readdatavalid), 64'd1);
    chk("t5_rd", 64'(bus.mem_readdata), 64'h21436587);
    step();
    chk("t5_bc0_single", 64'(bus.mem_readdatavalid), 64'd0);

    // INT_RET ignored in WAIT_RET, queued io waits for ST_ACK
    mem_cmd(1'b1, 30'h30, 4'b1111, 3'd1, 32'h0);
    step();
    bus.l15_ack = 1'b1;
    step();
    bus.l15_ack   = 1'b0;
    bus.mem_write = 1'b0;
    bus.io_read       = 1'b1;
    bus.io_address    = 16'h0008;
    bus.io_byteenable = 4'b1111;
    rsp(INT_RET, 64'hFFFFFFFF_FFFFFFFF, 64'h0);
    #1;
    chk("t6_int_ack", 64'(bus.l15_req_ack), 64'd1);
    step();
    bus.l15_rsp_val = 1'b0;
    step();
    chk("t6_kept_val", 64'(bus.l15_val), 64'd0);
    chk("t6_kept_rdv", 64'(bus.mem_readdatavalid), 64'd0);
    chk("t6_io_wait", 64'(bus.io_waitrequest), 64'd1);
    rsp(ST_ACK, 64'h0, 64'h0);
    step();
    bus.l15_rsp_val = 1'b0;
    step();
    chk("t6_io_val", 64'(bus.l15_val), 64'd1);
    chk("t6_io_addr", 64'(bus.l15_address), 64'(IOB | 40'h8));
    bus.l15_ack = 1'b1;
    step();
    bus.l15_ack = 1'b0;
    bus.io_read = 1'b0;
    rsp(LOAD_RET, 64'h0, 64'h0BADF00D_00000000);
    step();
    bus.l15_rsp_val = 1'b0;
    chk("t6_irdv", 64'(bus.io_readdatavalid), 64'd1);
    chk("t6_ird", 64'(bus.io_readdata), 64'h0DF0AD0B);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
